// File: rtl/cbus_arbiter_2to1.sv
// Two-master (ifetch m0 / data m1) to one-slave request/response arbiter.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 wins ties.
module cbus_arbiter_2to1 #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              m0_req_valid,
  input  logic              m0_req_is_write,
  input  logic [2:0]        m0_req_size,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [3:0]        m0_req_len,
  input  logic [3:0]        m0_req_strobe,
  input  logic [31:0]       m0_req_data,
  output logic              m0_resp_ready,
  output logic              m0_resp_last,
  output logic [31:0]       m0_resp_data,

  input  logic              m1_req_valid,
  input  logic              m1_req_is_write,
  input  logic [2:0]        m1_req_size,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [3:0]        m1_req_len,
  input  logic [3:0]        m1_req_strobe,
  input  logic [31:0]       m1_req_data,
  output logic              m1_resp_ready,
  output logic              m1_resp_last,
  output logic [31:0]       m1_resp_data,

  output logic              o_req_valid,
  output logic              o_req_is_write,
  output logic [2:0]        o_req_size,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [3:0]        o_req_len,
  output logic [3:0]        o_req_strobe,
  output logic [31:0]       o_req_data,
  input  logic              o_resp_ready,
  input  logic              o_resp_last,
  input  logic [31:0]       o_resp_data
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   tie_pick;
  logic   done;

  assign done = (state_q == BUSY) && o_resp_ready && o_resp_last;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the master that wins the next tie (the one not served last).
  logic prio_q, prio_d;
  assign tie_pick = prio_q;
  assign prio_d   = done ? ~grant_q : prio_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end
`else
  assign tie_pick = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          state_d = BUSY;
          grant_d = (m0_req_valid && m1_req_valid) ? tie_pick : m1_req_valid;
        end
      end
      BUSY: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request mux is transparent only while BUSY; IDLE (and reset) drives zeros.
  always_comb begin
    o_req_valid    = 1'b0;
    o_req_is_write = 1'b0;
    o_req_size     = '0;
    o_req_addr     = '0;
    o_req_len      = '0;
    o_req_strobe   = '0;
    o_req_data     = '0;
    m0_resp_ready  = 1'b0;
    m0_resp_last   = 1'b0;
    m1_resp_ready  = 1'b0;
    m1_resp_last   = 1'b0;
    if (state_q == BUSY) begin
      if (grant_q) begin
        o_req_valid    = m1_req_valid;
        o_req_is_write = m1_req_is_write;
        o_req_size     = m1_req_size;
        o_req_addr     = m1_req_addr;
        o_req_len      = m1_req_len;
        o_req_strobe   = m1_req_strobe;
        o_req_data     = m1_req_data;
        m1_resp_ready  = o_resp_ready;
        m1_resp_last   = o_resp_last;
      end else begin
        o_req_valid    = m0_req_valid;
        o_req_is_write = m0_req_is_write;
        o_req_size     = m0_req_size;
        o_req_addr     = m0_req_addr;
        o_req_len      = m0_req_len;
        o_req_strobe   = m0_req_strobe;
        o_req_data     = m0_req_data;
        m0_resp_ready  = o_resp_ready;
        m0_resp_last   = o_resp_last;
      end
    end
  end

  // Read data is broadcast; masters qualify it with their own ready.
  assign m0_resp_data = resetn ? o_resp_data : '0;
  assign m1_resp_data = resetn ? o_resp_data : '0;

endmodule

// File: tb/tb_cbus_arbiter_2to1.sv
// Directed self-checking bench for cbus_arbiter_2to1.
module tb_cbus_arbiter_2to1;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic resetn;
  logic m0_req_valid, m0_req_is_write, m1_req_valid, m1_req_is_write;
  logic [2:0] m0_req_size, m1_req_size, o_req_size;
  logic [ADDR_W-1:0] m0_req_addr, m1_req_addr, o_req_addr;
  logic [3:0] m0_req_len, m1_req_len, o_req_len;
  logic [3:0] m0_req_strobe, m1_req_strobe, o_req_strobe;
  logic [31:0] m0_req_data, m1_req_data, o_req_data;
  logic m0_resp_ready, m0_resp_last, m1_resp_ready, m1_resp_last;
  logic [31:0] m0_resp_data, m1_resp_data;
  logic o_req_valid, o_req_is_write;
  logic o_resp_ready, o_resp_last;
  logic [31:0] o_resp_data;

  int checks = 0;
  int failures = 0;
  logic exp_m1;

  always #5 clk = ~clk;

  cbus_arbiter_2to1 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req_valid(m0_req_valid), .m0_req_is_write(m0_req_is_write),
    .m0_req_size(m0_req_size), .m0_req_addr(m0_req_addr), .m0_req_len(m0_req_len),
    .m0_req_strobe(m0_req_strobe), .m0_req_data(m0_req_data),
    .m0_resp_ready(m0_resp_ready), .m0_resp_last(m0_resp_last), .m0_resp_data(m0_resp_data),
    .m1_req_valid(m1_req_valid), .m1_req_is_write(m1_req_is_write),
    .m1_req_size(m1_req_size), .m1_req_addr(m1_req_addr), .m1_req_len(m1_req_len),
    .m1_req_strobe(m1_req_strobe), .m1_req_data(m1_req_data),
    .m1_resp_ready(m1_resp_ready), .m1_resp_last(m1_resp_last), .m1_resp_data(m1_resp_data),
    .o_req_valid(o_req_valid), .o_req_is_write(o_req_is_write), .o_req_size(o_req_size),
    .o_req_addr(o_req_addr), .o_req_len(o_req_len), .o_req_strobe(o_req_strobe),
    .o_req_data(o_req_data),
    .o_resp_ready(o_resp_ready), .o_resp_last(o_resp_last), .o_resp_data(o_resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_req_valid = 0; m0_req_is_write = 0; m0_req_size = 0; m0_req_addr = 0;
    m0_req_len = 0; m0_req_strobe = 0; m0_req_data = 0;
    m1_req_valid = 0; m1_req_is_write = 0; m1_req_size = 0; m1_req_addr = 0;
    m1_req_len = 0; m1_req_strobe = 0; m1_req_data = 0;
    o_resp_ready = 0; o_resp_last = 0; o_resp_data = 0;
  endtask

  initial begin
    // Reset: outputs forced to zero even with live inputs
    clear_inputs();
    resetn = 0;
    m0_req_valid = 1; m0_req_addr = 32'h1111_2220;
    o_resp_ready = 1; o_resp_last = 1; o_resp_data = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_oreq_valid", o_req_valid, 0);
    chk("rst_oreq_addr", o_req_addr, 0);
    chk("rst_m0_ready", m0_resp_ready, 0);
    chk("rst_m0_data", m0_resp_data, 0);
    chk("rst_m1_data", m1_resp_data, 0);
    clear_inputs();
    @(negedge clk) resetn = 1;

    // Stray response while IDLE
    @(negedge clk);
    o_resp_ready = 1; o_resp_last = 1; o_resp_data = 32'hDEAD_BEEF;
    #1;
    chk("idle_m0_ready", m0_resp_ready, 0);
    chk("idle_m1_ready", m1_resp_ready, 0);
    chk("idle_m1_data", m1_resp_data, 32'hDEAD_BEEF);
    @(negedge clk);
    o_resp_ready = 0; o_resp_last = 0;
    #1 chk("idle_oreq_valid", o_req_valid, 0);

    // Single-beat m0 read
    m0_req_valid = 1; m0_req_addr = 32'hBFC0_0000; m0_req_len = 0; m0_req_size = 3'd2;
    #1 chk("r1_lat0", o_req_valid, 0);
    @(negedge clk); #1;
    chk("r1_valid", o_req_valid, 1);
    chk("r1_addr", o_req_addr, 32'hBFC0_0000);
    chk("r1_size", o_req_size, 3'd2);
    o_resp_ready = 1; o_resp_last = 1; o_resp_data = 32'h3C08_0001;
    #1;
    chk("r1_m0_ready", m0_resp_ready, 1);
    chk("r1_m0_last", m0_resp_last, 1);
    chk("r1_m0_data", m0_resp_data, 32'h3C08_0001);
    chk("r1_m1_ready", m1_resp_ready, 0);
    @(negedge clk);
    o_resp_ready = 0; o_resp_last = 0;
    #1 chk("r1_bubble", o_req_valid, 0);
    m0_req_valid = 0;

    // m1 4-beat write while m0 waits
    @(negedge clk);
    m1_req_valid = 1; m1_req_is_write = 1; m1_req_size = 3'd2; m1_req_addr = 32'h1000_0040;
    m1_req_len = 4'd3; m1_req_strobe = 4'hF; m1_req_data = 32'hAABB_CCDD;
    m0_req_valid = 1; m0_req_addr = 32'hBFC0_0010; m0_req_len = 0;
    #1 chk("w_lat0", o_req_valid, 0);
    @(negedge clk); #1;
    chk("w_addr", o_req_addr, 32'h1000_0040);
    chk("w_is_write", o_req_is_write, 1);
    chk("w_len", o_req_len, 4'd3);
    chk("w_strobe", o_req_strobe, 4'hF);
    chk("w_data", o_req_data, 32'hAABB_CCDD);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      o_resp_ready = 1; o_resp_last = (b == 3);
      #1;
      chk("w_m1_ready", m1_resp_ready, 1);
      chk("w_m1_last", m1_resp_last, (b == 3));
      chk("w_m0_ready", m0_resp_ready, 0);
      chk("w_m0_last", m0_resp_last, 0);
    end
    @(negedge clk);
    m1_req_valid = 0; o_resp_ready = 0; o_resp_last = 0;
    #1 chk("w_bubble", o_req_valid, 0);
    @(negedge clk); #1;
    chk("w_m0_grant_valid", o_req_valid, 1);
    chk("w_m0_grant_addr", o_req_addr, 32'hBFC0_0010);
    chk("w_m0_grant_wr", o_req_is_write, 0);
    o_resp_ready = 1; o_resp_last = 1;
    #1;
    chk("w_m0_done", m0_resp_ready, 1);
    chk("w_m1_quiet", m1_resp_ready, 0);
    @(negedge clk);
    clear_inputs();

    // Both masters requesting from reset exit
    resetn = 0;
    @(negedge clk);
    m0_req_valid = 1; m0_req_addr = 32'h0000_00A0;
    m1_req_valid = 1; m1_req_addr = 32'h0000_00A1;
    resetn = 1;
    #1 chk("arb_lat0", o_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_m1 = (i % 2 == 1);
`else
      exp_m1 = 1'b1;
`endif
      chk("arb_addr", o_req_addr, exp_m1 ? 32'h0000_00A1 : 32'h0000_00A0);
      o_resp_ready = 1; o_resp_last = 1;
      #1;
      chk("arb_m1_ready", m1_resp_ready, exp_m1);
      chk("arb_m0_ready", m0_resp_ready, !exp_m1);
      @(negedge clk);
      o_resp_ready = 0; o_resp_last = 0;
      #1 chk("arb_bubble", o_req_valid, 0);
    end
    clear_inputs();

    // Reset in the middle of a 4-beat read
    resetn = 0;
    @(negedge clk) resetn = 1;
    @(negedge clk);
    m0_req_valid = 1; m0_req_addr = 32'hBFC0_0100; m0_req_len = 4'd3;
    @(negedge clk); #1;
    chk("mr_len", o_req_len, 4'd3);
    o_resp_ready = 1; o_resp_last = 0; o_resp_data = 32'h0000_0B00;
    @(negedge clk);
    o_resp_data = 32'h0000_0B01;
    @(negedge clk);
    o_resp_data = 32'h0000_0B02;
    resetn = 0;
    #1;
    chk("mr_rst_m0_ready", m0_resp_ready, 0);
    chk("mr_rst_oreq_valid", o_req_valid, 0);
    chk("mr_rst_oreq_addr", o_req_addr, 0);
    chk("mr_rst_m0_data", m0_resp_data, 0);
    @(negedge clk);
    o_resp_ready = 1; o_resp_last = 1;
    resetn = 1;
    #1;
    chk("mr_stray_ready", m0_resp_ready, 0);
    chk("mr_stray_last", m0_resp_last, 0);
    @(negedge clk);
    o_resp_ready = 0; o_resp_last = 0;
    #1;
    chk("mr_regrant_valid", o_req_valid, 1);
    chk("mr_regrant_addr", o_req_addr, 32'hBFC0_0100);
    o_resp_ready = 1; o_resp_last = 1;
    #1 chk("mr_regrant_done", m0_resp_ready, 1);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
